// File: rtl/project3_aluv_top.sv
// Execute-stage ALU with built-in ALU-control decode for the RV32I datapath.
// Ports: clk, rst_n (async, active-low); aluop[1:0], funccode[9:0] select the
//   operation; a, b operands; result, zero, overflow, carryout are registered.
module project3_aluv_top #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       aluop,
    input  logic [9:0]       funccode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             carryout
);

    localparam int SW = $clog2(WIDTH);

    typedef enum logic [3:0] {
        OP_ADD,
        OP_SUB,
        OP_SLL,
        OP_SLT,
        OP_SLTU,
        OP_XOR,
        OP_SRL,
        OP_SRA,
        OP_OR,
        OP_AND
    } alu_op_t;

    logic [2:0] f3;
    logic       f7b5;
    alu_op_t    op;

    assign f3   = funccode[2:0];
    assign f7b5 = funccode[8];

    always_comb begin
        op = OP_ADD;
        unique case (aluop)
            2'b00: op = OP_ADD;
            2'b01: op = OP_SUB;
            default: begin
                unique case (f3)
                    // addi has no funct7, so only R-type honours bit 8 here
                    3'b000: op = (f7b5 && aluop == 2'b10) ? OP_SUB : OP_ADD;
                    3'b001: op = OP_SLL;
                    3'b010: op = OP_SLT;
                    3'b011: op = OP_SLTU;
                    3'b100: op = OP_XOR;
                    3'b101: op = f7b5 ? OP_SRA : OP_SRL;
                    3'b110: op = OP_OR;
                    default: op = OP_AND;
                endcase
            end
        endcase
    end

    logic             sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ov;
    logic [SW-1:0]    shamt;

    assign sub   = (op == OP_SUB);
    assign b_eff = sub ? ~b : b;
    assign shamt = b[SW-1:0];

    // Single shared adder; subtraction is a + ~b + 1.
    assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    assign ov = (a[WIDTH-1] == b_eff[WIDTH-1]) &&
                (sum[WIDTH-1] != a[WIDTH-1]);

    logic [WIDTH-1:0] res_d;
    logic             arith;

    assign arith = (op == OP_ADD) || (op == OP_SUB);

    always_comb begin
        res_d = '0;
        unique case (op)
            OP_ADD,
            OP_SUB:  res_d = sum;
            OP_SLL:  res_d = a << shamt;
            OP_SLT:  res_d = {{(WIDTH-1){1'b0}},
                              ($signed(a) < $signed(b))};
            OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_XOR:  res_d = a ^ b;
            OP_SRL:  res_d = a >> shamt;
            OP_SRA:  res_d = $unsigned($signed(a) >>> shamt);
            OP_OR:   res_d = a | b;
            OP_AND:  res_d = a & b;
            default: res_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result   <= '0;
            zero     <= 1'b1;
            overflow <= 1'b0;
            carryout <= 1'b0;
        end else begin
            result   <= res_d;
            zero     <= (res_d == '0);
            overflow <= arith & ov;
            carryout <= arith & cout;
        end
    end

endmodule

// File: tb/tb_project3_aluv_top.sv
// Directed-vector bench for project3_aluv_top.
// Hand-computed expectations for decode, adder flags and async reset.
module tb_project3_aluv_top;

    logic        clk;
    logic        rst_n;
    logic [1:0]  aluop;
    logic [9:0]  funccode;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        carryout;

    int passed;
    int total;

    project3_aluv_top #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .aluop    (aluop),
        .funccode (funccode),
        .a        (a),
        .b        (b),
        .result   (result),
        .zero     (zero),
        .overflow (overflow),
        .carryout (carryout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%h want=%h", tag, got, exp);
    endtask

    task automatic run(input string tag,
                       input logic [1:0] op,
                       input logic [9:0] f,
                       input logic [31:0] va,
                       input logic [31:0] vb,
                       input logic [31:0] er,
                       input logic ez,
                       input logic eov,
                       input logic ec);
        @(negedge clk);
        aluop    = op;
        funccode = f;
        a        = va;
        b        = vb;
        @(posedge clk);
        #1;
        check({tag, ".res"}, result, er);
        check({tag, ".z"}, {31'b0, zero}, {31'b0, ez});
        check({tag, ".ov"}, {31'b0, overflow}, {31'b0, eov});
        check({tag, ".c"}, {31'b0, carryout}, {31'b0, ec});
    endtask

    initial begin
        passed   = 0;
        total    = 0;
        rst_n    = 1'b0;
        aluop    = 2'b00;
        funccode = 10'd0;
        a        = 32'd0;
        b        = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.res", result, 32'd0);
        check("rst.z", {31'b0, zero}, 32'd1);
        check("rst.ov", {31'b0, overflow}, 32'd0);
        check("rst.c", {31'b0, carryout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run("and",  2'b10, 10'd7, 32'd7, 32'd5, 32'd5, 0, 0, 0);
        run("or",   2'b10, 10'd6, 32'd7, 32'd5, 32'd7, 0, 0, 0);
        run("lw",   2'b00, 10'd2, 32'd7, 32'd5, 32'hC, 0, 0, 0);
        run("ldig", 2'b00, 10'h3FF, 32'd7, 32'd5, 32'hC, 0, 0, 0);
        run("beq0", 2'b01, 10'd0, 32'd1, 32'd1, 32'd0, 1, 0, 1);
        run("beq1", 2'b01, 10'h107, 32'd7, 32'd5, 32'd2, 0, 0, 1);
        run("add",  2'b10, 10'd0, 32'h17, 32'hD, 32'h24, 0, 0, 0);
        run("sub",  2'b10, 10'd256, 32'h17, 32'hD, 32'hA, 0, 0, 1);
        run("addov", 2'b10, 10'd0, 32'h7FFFFFFF, 32'd1,
            32'h80000000, 0, 1, 0);
        run("addnn", 2'b10, 10'd0, 32'hFFFFFFFF, 32'h80000000,
            32'h7FFFFFFF, 0, 1, 1);
        run("addos", 2'b10, 10'd0, 32'h80000002, 32'd1,
            32'h80000003, 0, 0, 0);
        run("subos", 2'b10, 10'd256, 32'h80000002, 32'd1,
            32'h80000001, 0, 0, 1);
        run("addwr", 2'b10, 10'd0, 32'hFFFFFFFF, 32'd1,
            32'd0, 1, 0, 1);
        run("sll",  2'b10, 10'd1, 32'd1, 32'h21, 32'd2, 0, 0, 0);
        run("slt",  2'b10, 10'd2, 32'hFFFFFFFF, 32'd1, 32'd1, 0, 0, 0);
        run("sltu", 2'b10, 10'd3, 32'hFFFFFFFF, 32'd1, 32'd0, 1, 0, 0);
        run("xor",  2'b10, 10'd4, 32'hF0F0, 32'hFF00, 32'h0FF0, 0, 0, 0);
        run("srl",  2'b10, 10'd5, 32'h80000000, 32'd4,
            32'h08000000, 0, 0, 0);
        run("sra",  2'b10, 10'h105, 32'h80000000, 32'd4,
            32'hF8000000, 0, 0, 0);
        run("srai", 2'b11, 10'h105, 32'hF0000000, 32'd8,
            32'hFFF00000, 0, 0, 0);
        run("addi", 2'b11, 10'h100, 32'd5, 32'd3, 32'd8, 0, 0, 0);
        run("andz", 2'b10, 10'd7, 32'hF0, 32'h0F, 32'd0, 1, 0, 0);
        run("xorbig", 2'b11, 10'd4, 32'h7FFFFFFF, 32'hFFFFFFFF,
            32'h80000000, 0, 0, 0);

        // Leave a non-zero result, then reset between edges.
        run("pre", 2'b00, 10'd0, 32'hFFFFFFFF, 32'h80000000,
            32'h7FFFFFFF, 0, 1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.res", result, 32'd0);
        check("arst.z", {31'b0, zero}, 32'd1);
        check("arst.ov", {31'b0, overflow}, 32'd0);
        check("arst.c", {31'b0, carryout}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("hold.res", result, 32'd0);
        check("hold.z", {31'b0, zero}, 32'd1);
        check("hold.c", {31'b0, carryout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel.res", result, 32'h7FFFFFFF);
        check("rel.ov", {31'b0, overflow}, 32'd1);
        check("rel.c", {31'b0, carryout}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
